// File: rtl/snail_imem_if.sv
// Bus bundle between the SNAIL core / image loader and the instruction memory.
//   rom_addr  : fetch address from the core
//   rom_data  : instruction word returned to the core
//   cpu_rst_  : active-low reset to the core
//   ld_start  : single-cycle request to begin a new image load
//   ld_valid  : ld_data / ld_last are valid
//   ld_data   : image byte
//   ld_last   : current byte is the final byte of the image
//   ld_ready  : memory can accept a byte
//   ld_err    : sticky flag, image exceeded 2^AW words
//   word_cnt  : words written by the current or last load
// The slave modport is the memory side; the master modport is the core/loader side.
interface snail_imem_if #(
    parameter int AW = 8,
    parameter int DW = 24
);
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          cpu_rst_;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_err;
    logic [AW:0]   word_cnt;

    modport slave (
        input  rom_addr, ld_start, ld_valid, ld_data, ld_last,
        output rom_data, cpu_rst_, ld_ready, ld_err, word_cnt
    );

    modport master (
        output rom_addr, ld_start, ld_valid, ld_data, ld_last,
        input  rom_data, cpu_rst_, ld_ready, ld_err, word_cnt
    );
endinterface

// File: rtl/snail_imem.sv
// snail_imem: instruction memory for the SNAIL core fetch port.
// Holds a 2^AW x DW program store. In LOAD it assembles a byte-serial image
// (big-endian, 3 bytes per word) into memory while holding the core in reset;
// on the last byte it switches to RUN, releases the core and serves fetches
// combinationally.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : snail_imem_if.slave (fetch port, load port, status)
module snail_imem #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic         clk,
    input  logic         rst,
    snail_imem_if.slave  bus
);
    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [7:0]    hi_reg, hi_next;     // byte 0 of the word being assembled
    logic [7:0]    mid_reg, mid_next;   // byte 1 of the word being assembled
    logic [AW-1:0] wr_addr_reg, wr_addr_next;
    logic [AW:0]   word_cnt_reg, word_cnt_next;
    logic          ld_err_reg, ld_err_next;
    logic          cpu_rst_n_reg, cpu_rst_n_next;

    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            byte_idx_reg  <= 2'd0;
            hi_reg        <= 8'h00;
            mid_reg       <= 8'h00;
            wr_addr_reg   <= '0;
            word_cnt_reg  <= '0;
            ld_err_reg    <= 1'b0;
            cpu_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_idx_reg  <= byte_idx_next;
            hi_reg        <= hi_next;
            mid_reg       <= mid_next;
            wr_addr_reg   <= wr_addr_next;
            word_cnt_reg  <= word_cnt_next;
            ld_err_reg    <= ld_err_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
        end
    end

    // Memory contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_reg] <= mem_wdata;
        end
    end

    always_comb begin
        state_next     = state_reg;
        byte_idx_next  = byte_idx_reg;
        hi_next        = hi_reg;
        mid_next       = mid_reg;
        wr_addr_next   = wr_addr_reg;
        word_cnt_next  = word_cnt_reg;
        ld_err_next    = ld_err_reg;
        cpu_rst_n_next = cpu_rst_n_reg;
        mem_we         = 1'b0;
        mem_wdata      = '0;

        case (state_reg)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    // Word as it would look if completed by this byte; missing
                    // low bytes of a short trailing word are zero-padded.
                    case (byte_idx_reg)
                        2'd0:    mem_wdata = {bus.ld_data, 8'h00, 8'h00};
                        2'd1:    mem_wdata = {hi_reg, bus.ld_data, 8'h00};
                        default: mem_wdata = {hi_reg, mid_reg, bus.ld_data};
                    endcase
                    if (byte_idx_reg == 2'd0) hi_next  = bus.ld_data;
                    if (byte_idx_reg == 2'd1) mid_next = bus.ld_data;

                    if ((byte_idx_reg == 2'd2) || bus.ld_last) begin
                        byte_idx_next = 2'd0;
                        // word_cnt saturates at exactly 2^AW, so its MSB marks a full store.
                        if (word_cnt_reg[AW]) begin
                            ld_err_next = 1'b1;
                        end else begin
                            mem_we        = 1'b1;
                            wr_addr_next  = wr_addr_reg + 1'b1;
                            word_cnt_next = word_cnt_reg + 1'b1;
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end

                    if (bus.ld_last) begin
                        state_next     = ST_RUN;
                        cpu_rst_n_next = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.ld_start) begin
                    state_next     = ST_LOAD;
                    cpu_rst_n_next = 1'b0;
                    ld_err_next    = 1'b0;
                    word_cnt_next  = '0;
                    wr_addr_next   = '0;
                    byte_idx_next  = 2'd0;
                end
            end
        endcase
    end

    assign bus.ld_ready = (state_reg == ST_LOAD);
    assign bus.rom_data = (state_reg == ST_RUN) ? mem[bus.rom_addr] : '0;
    assign bus.cpu_rst_ = cpu_rst_n_reg;
    assign bus.ld_err   = ld_err_reg;
    assign bus.word_cnt = word_cnt_reg;
endmodule
